// File: rtl/truth_table_checker.sv
// truth_table_checker
//
// Hardware exerciser for a small combinational gate network. After a start
// request it walks every input vector 0 .. 2^N_IN-1 in ascending order, holds
// each one for SETTLE+1 cycles, samples the DUT response on the last of those
// cycles and compares it with the expected truth table EXPECT. A run ends with
// a one-cycle done pulse and a pass flag; the error count and the lowest
// failing vector stay readable until the next run is started.
//
// Parameters:
//   N_IN    number of DUT inputs (vectors 0 .. 2^N_IN-1)
//   SETTLE  extra cycles a vector is held before it is sampled (0 allowed)
//   EXPECT  expected DUT output, bit k belongs to vector k
//
// Ports:
//   clk              clock, everything on the rising edge
//   rst_n            synchronous active-low reset
//   start            begin a run (only honoured while idle)
//   dut_in           vector driven to the DUT, bit 0 is the first DUT input
//   dut_out          DUT response
//   busy             a run is in progress
//   done             one-cycle pulse when a run completes
//   pass             last completed run had no mismatches
//   err_count        mismatches in the last or current run
//   first_fail       lowest vector index that mismatched
//   first_fail_valid first_fail holds a real value

module truth_table_checker #(
  parameter int                 N_IN   = 2,
  parameter int                 SETTLE = 2,
  parameter logic [2**N_IN-1:0] EXPECT = 4'b1110
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [N_IN-1:0] dut_in,
  input  logic            dut_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_fail,
  output logic            first_fail_valid
);

  // The settle counter only has to reach SETTLE-1; keep it at least one bit
  // wide so the declaration stays legal for SETTLE of 0 or 1.
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam logic [N_IN-1:0] VEC_LAST = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SAMPLE = 2'd2,
    FINISH = 2'd3
  } state_t;

  // With no settle time a vector goes straight to its sample cycle, so the
  // APPLY state is skipped entirely.
  localparam state_t FIRST_STATE = (SETTLE == 0) ? SAMPLE : APPLY;

  state_t          state, state_next;
  logic [CW-1:0]   cnt, cnt_next;
  logic [N_IN-1:0] vec, vec_next;
  logic [N_IN:0]   err, err_next;
  logic [N_IN-1:0] ff, ff_next;
  logic            ffv, ffv_next;
  logic            pass_r, pass_next;
  logic            mismatch;

  // State and result registers. Reset is synchronous, so a reset in the
  // middle of a run simply discards everything at the next edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      vec    <= '0;
      err    <= '0;
      ff     <= '0;
      ffv    <= 1'b0;
      pass_r <= 1'b0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      vec    <= vec_next;
      err    <= err_next;
      ff     <= ff_next;
      ffv    <= ffv_next;
      pass_r <= pass_next;
    end
  end

  // Next-state and datapath update. Every register holds by default; the
  // sample cycle is the only place results change during a run.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    vec_next   = vec;
    err_next   = err;
    ff_next    = ff;
    ffv_next   = ffv;
    pass_next  = pass_r;
    mismatch   = (dut_out != EXPECT[vec]);

    case (state)
      IDLE: begin
        if (start) begin
          err_next   = '0;
          ffv_next   = 1'b0;
          pass_next  = 1'b0;
          vec_next   = '0;
          cnt_next   = '0;
          state_next = FIRST_STATE;
        end
      end

      APPLY: begin
        if (cnt == CNT_LAST) begin
          cnt_next   = '0;
          state_next = SAMPLE;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end

      SAMPLE: begin
        if (mismatch) begin
          err_next = err + (N_IN + 1)'(1);
          if (!ffv) begin
            ff_next  = vec;
            ffv_next = 1'b1;
          end
        end
        // The last vector is held (no wrap) so dut_in keeps showing it
        // after the run; pass must already include this final sample.
        if (vec == VEC_LAST) begin
          pass_next  = (err_next == '0);
          state_next = FINISH;
        end else begin
          vec_next   = vec + N_IN'(1);
          state_next = FIRST_STATE;
        end
      end

      FINISH: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign dut_in           = vec;
  assign busy             = (state == APPLY) || (state == SAMPLE);
  assign done             = (state == FINISH);
  assign pass             = pass_r;
  assign err_count        = err;
  assign first_fail       = ff;
  assign first_fail_valid = ffv;

endmodule
